// File: rtl/mdu_pkg.sv
// ---------------------------------------------------------------------------
// mdu_pkg
// Shared definitions for the iterative RV M-extension unit:
//   - funct3 encodings of the eight M-ops
//   - 3-bit FSM state encodings
//   - helpers that classify which operands of an op are treated as signed
// ---------------------------------------------------------------------------
package mdu_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PREP = 3'd1;
    localparam logic [2:0] S_CALC = 3'd2;
    localparam logic [2:0] S_FIX  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    // MUL only needs the low half, which is identical for signed and
    // unsigned operands, so it is run on raw (unsigned) operands.
    function automatic logic a_is_signed(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    function automatic logic b_is_signed(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage

// File: rtl/mdu_step.sv
// ---------------------------------------------------------------------------
// mdu_step
// One combinational iteration of the sequential multiplier/divider.
//   mode        0 = shift-add multiply step, 1 = restoring divide step
//   acc_hi      mul: running upper product half; div: partial remainder
//   acc_lo      mul: multiplier / lower product bits; div: dividend / quotient
//   operand     mul: multiplicand magnitude; div: divisor magnitude
//   acc_hi_nxt  updated acc_hi
//   acc_lo_nxt  updated acc_lo
// ---------------------------------------------------------------------------
module mdu_step #(
    parameter int XLEN = 32
) (
    input  logic            mode,
    input  logic [XLEN-1:0] acc_hi,
    input  logic [XLEN-1:0] acc_lo,
    input  logic [XLEN-1:0] operand,
    output logic [XLEN-1:0] acc_hi_nxt,
    output logic [XLEN-1:0] acc_lo_nxt
);

    logic [XLEN:0] sum;
    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    always_comb begin
        sum        = '0;
        shifted    = '0;
        diff       = '0;
        acc_hi_nxt = acc_hi;
        acc_lo_nxt = acc_lo;
        if (!mode) begin
            // Add the multiplicand when the current multiplier bit is set,
            // then shift the whole {carry, hi, lo} right by one.
            sum        = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : '0);
            acc_hi_nxt = sum[XLEN:1];
            acc_lo_nxt = {sum[0], acc_lo[XLEN-1:1]};
        end else begin
            // Bring the next dividend bit into the remainder and try the
            // subtraction; a borrow means the trial fails and is discarded.
            shifted = {acc_hi, acc_lo[XLEN-1]};
            diff    = shifted - {1'b0, operand};
            if (!diff[XLEN]) begin
                acc_hi_nxt = diff[XLEN-1:0];
                acc_lo_nxt = {acc_lo[XLEN-2:0], 1'b1};
            end else begin
                acc_hi_nxt = shifted[XLEN-1:0];
                acc_lo_nxt = {acc_lo[XLEN-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/mul_div_seq.sv
// ---------------------------------------------------------------------------
// mul_div_seq
// Iterative RV M-extension unit sitting beside the EX-stage ALU. Runs one
// shift-add / shift-subtract step per clock on operand magnitudes and holds
// the pipeline via stall_req until the result is ready.
//   clk, reset        clock; synchronous active-high reset
//   start             M-op present in EX (only sampled in IDLE)
//   flush             abort any op in flight, no done pulse
//   funct3            M-op selector
//   rs1_val, rs2_val  operand A / dividend, operand B / divisor
//   busy              high in every state except IDLE
//   stall_req         hold EX until the op completes
//   done              one-cycle pulse, result valid
//   result            held from DONE until the next op writes it
// ---------------------------------------------------------------------------
module mul_div_seq
    import mdu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    output logic            busy,
    output logic            stall_req,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);

    logic [2:0]      state_q;
    logic [2:0]      op_q;
    logic [XLEN-1:0] a_q, b_q;
    logic [XLEN-1:0] acc_hi_q, acc_lo_q, opnd_q;
    logic [CW-1:0]   cnt_q;
    logic            neg_q, rneg_q, dz_q, ovf_q;
    logic [XLEN-1:0] result_q;

    logic [XLEN-1:0] step_hi_d, step_lo_d;
    logic            a_neg, b_neg, div_zero, div_ovf;
    logic [XLEN-1:0] a_mag, b_mag;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0] quo_s, rem_s, fix_d;

    mdu_step #(.XLEN(XLEN)) u_step (
        .mode       (op_q[2]),
        .acc_hi     (acc_hi_q),
        .acc_lo     (acc_lo_q),
        .operand    (opnd_q),
        .acc_hi_nxt (step_hi_d),
        .acc_lo_nxt (step_lo_d)
    );

    // Operand conditioning used in PREP.
    always_comb begin
        a_neg    = a_is_signed(op_q) & a_q[XLEN-1];
        b_neg    = b_is_signed(op_q) & b_q[XLEN-1];
        a_mag    = a_neg ? -a_q : a_q;
        b_mag    = b_neg ? -b_q : b_q;
        div_zero = op_q[2] & (b_q == '0);
        // Only DIV/REM (funct3[0]==0 among divides) can overflow.
        div_ovf  = op_q[2] & ~op_q[0] & ~div_zero
                 & (a_q == {1'b1, {(XLEN-1){1'b0}}}) & (&b_q);
    end

    // Sign correction and result selection used in FIX.
    always_comb begin
        prod_s = neg_q  ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};
        quo_s  = neg_q  ? -acc_lo_q : acc_lo_q;
        rem_s  = rneg_q ? -acc_hi_q : acc_hi_q;
        fix_d  = '0;
        case (op_q)
            F3_MUL:                       fix_d = prod_s[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: fix_d = prod_s[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:              fix_d = dz_q ? '1 : (ovf_q ? a_q : quo_s);
            default:                      fix_d = dz_q ? a_q : (ovf_q ? '0 : rem_s);
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            opnd_q   <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            dz_q     <= 1'b0;
            ovf_q    <= 1'b0;
            result_q <= '0;
        end else if (flush) begin
            state_q <= S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        op_q    <= funct3;
                        a_q     <= rs1_val;
                        b_q     <= rs2_val;
                        state_q <= S_PREP;
                    end
                end
                S_PREP: begin
                    // Quotient and product share the same sign rule;
                    // the remainder follows the dividend.
                    neg_q    <= a_neg ^ b_neg;
                    rneg_q   <= a_neg;
                    acc_hi_q <= '0;
                    acc_lo_q <= a_mag;
                    opnd_q   <= b_mag;
                    cnt_q    <= CW'(XLEN-1);
                    dz_q     <= div_zero;
                    ovf_q    <= div_ovf;
                    state_q  <= (div_zero | div_ovf) ? S_FIX : S_CALC;
                end
                S_CALC: begin
                    acc_hi_q <= step_hi_d;
                    acc_lo_q <= step_lo_d;
                    if (cnt_q == '0) state_q <= S_FIX;
                    else             cnt_q   <= cnt_q - 1'b1;
                end
                S_FIX: begin
                    result_q <= fix_d;
                    state_q  <= S_DONE;
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign stall_req = (start & (state_q == S_IDLE) & ~flush) | (busy & (state_q != S_DONE));
    assign result    = result_q;

endmodule

// File: tb/tb_mul_div_seq.sv
module tb_mul_div_seq;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            reset, start, flush;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rs1_val, rs2_val;
    logic            busy, stall_req, done;
    logic [XLEN-1:0] result;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    typedef struct {
        logic [31:0] res;
        int          due;
        logic [2:0]  f3;
    } exp_t;
    exp_t sb_q[$];

    mul_div_seq #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .flush     (flush),
        .funct3    (funct3),
        .rs1_val   (rs1_val),
        .rs2_val   (rs2_val),
        .busy      (busy),
        .stall_req (stall_req),
        .done      (done),
        .result    (result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, outstanding=%0d", sb_q.size());
        $fatal(1, "watchdog");
    end

    // Reference model: RISC-V M semantics from plain 64-bit / integer arithmetic.
    function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] sa, sb, ua, ub, p;
        int          ia, ib;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'b0, a};
        ub = {32'b0, b};
        ia = a;
        ib = b;
        case (f3)
            3'b000: begin p = ua * ub; return p[31:0]; end
            3'b001: begin p = sa * sb; return p[63:32]; end
            3'b010: begin p = sa * ub; return p[63:32]; end
            3'b011: begin p = ua * ub; return p[63:32]; end
            3'b100: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return ia / ib;
            end
            3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'b110: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return ia % ib;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Edges from the start edge to the edge after which done is visible:
    // cycles are numbered so the one following edge k is cycle k+1.
    function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (f3[2] && b == 0) return 2;
        if ((f3 == 3'b100 || f3 == 3'b110) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
        return XLEN + 2;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        exp_t e;
        if (!reset && done) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: got done with result %h expected no done", result);
            end else begin
                e = sb_q.pop_front();
                n_cmp++;
                if (result !== e.res) begin
                    n_bad++;
                    $display("FAIL result f3=%0d: got %h expected %h", e.f3, result, e.res);
                end
                n_cmp++;
                if (cyc != e.due) begin
                    n_bad++;
                    $display("FAIL latency f3=%0d: done at edge %0d expected edge %0d", e.f3, cyc, e.due);
                end
            end
        end
    end

    // Drive start for exactly one edge at the next negedge; returns the start edge number.
    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, output int t_edge);
        @(negedge clk);
        funct3 = f3; rs1_val = a; rs2_val = b; start = 1'b1;
        t_edge = cyc + 1;
        #1 check("stall_on_start", {31'b0, stall_req}, 32'd1);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input int poke_at);
        int    t, n;
        logic  stall_ok;
        exp_t  e;
        e.res = ref_model(f3, a, b);
        e.f3  = f3;
        @(negedge clk);
        funct3 = f3; rs1_val = a; rs2_val = b; start = 1'b1;
        t = cyc + 1;
        e.due = t + ref_latency(f3, a, b);
        sb_q.push_back(e);
        #1 check("stall_on_start", {31'b0, stall_req}, 32'd1);
        @(negedge clk);
        n = 0;
        stall_ok = 1'b1;
        while (!done && n < 200) begin
            if (!stall_req) stall_ok = 1'b0;
            if (poke_at != 0 && n == poke_at) begin
                start = 1'b1; funct3 = 3'b101; rs1_val = 32'd100; rs2_val = 32'd7;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        if (n >= 200) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_timeout f3=%0d: got no done expected done within 200 cycles", f3);
        end else begin
            check("stall_before_done", {31'b0, stall_ok}, 32'd1);
            check("stall_at_done", {31'b0, stall_req}, 32'd0);
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return $urandom_range(0, 15);
            default: return $urandom();
        endcase
    endfunction

    initial begin
        int          t;
        logic [31:0] r_before;
        reset = 1'b1; start = 1'b0; flush = 1'b0;
        funct3 = 3'b0; rs1_val = '0; rs2_val = '0;
        repeat (3) @(negedge clk);
        check("reset_busy",   {31'b0, busy},      32'd0);
        check("reset_done",   {31'b0, done},      32'd0);
        check("reset_stall",  {31'b0, stall_req}, 32'd0);
        check("reset_result", result,             32'd0);
        reset = 1'b0;

        // Directed cases
        run_op(3'b000, 32'd7,          32'hFFFF_FFFD, 0);
        run_op(3'b001, 32'h8000_0000,  32'h8000_0000, 0);
        run_op(3'b011, 32'h8000_0000,  32'h8000_0000, 0);
        run_op(3'b010, 32'hFFFF_FFFF,  32'd2,         0);
        run_op(3'b100, 32'hFFFF_FFF9,  32'd2,         0);
        run_op(3'b110, 32'hFFFF_FFF9,  32'd2,         0);
        run_op(3'b101, 32'hFFFF_FFF9,  32'd2,         0);
        run_op(3'b101, 32'd5,          32'd0,         0);
        run_op(3'b111, 32'd5,          32'd0,         0);
        run_op(3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 0);
        run_op(3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 0);
        run_op(3'b100, 32'd123,        32'd0,         0);

        // Flush mid-CALC: no done, result unchanged
        r_before = result;
        issue(3'b000, 32'd9, 32'd9, t);
        while (cyc < t + 9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", {31'b0, busy}, 32'd0);
        check("flush_done", {31'b0, done}, 32'd0);
        repeat (40) @(negedge clk);
        check("flush_result_kept", result, r_before);

        // start pulsed while busy is ignored
        run_op(3'b000, 32'd3, 32'd5, 6);

        // flush and start together in IDLE: start dropped
        @(negedge clk);
        funct3 = 3'b000; rs1_val = 32'd2; rs2_val = 32'd2; start = 1'b1; flush = 1'b1;
        #1 check("flush_start_stall", {31'b0, stall_req}, 32'd0);
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("flush_start_busy", {31'b0, busy}, 32'd0);
        repeat (40) @(negedge clk);

        // Randomized ops against the reference model
        for (int i = 0; i < 40; i++) begin
            run_op(3'($urandom_range(0, 7)), pick(), pick(), 0);
        end

        // Reset mid-CALC
        issue(3'b101, 32'hDEAD_BEEF, 32'd3, t);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midreset_busy",   {31'b0, busy},      32'd0);
        check("midreset_done",   {31'b0, done},      32'd0);
        check("midreset_stall",  {31'b0, stall_req}, 32'd0);
        check("midreset_result", result,             32'd0);
        reset = 1'b0;
        repeat (40) @(negedge clk);

        check("scoreboard_drained", sb_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
